// File: rtl/reflet_run_monitor.sv
// reflet_run_monitor: debug counter, debug-address log FIFO, watchdog and sticky PASS/FAIL verdict.
// Define REFLET_RUN_MONITOR_LOG_EN to build the debug-address log FIFO.
module reflet_run_monitor #(
    parameter int wordsize       = 16,
    parameter int expected_debug = 2,
    parameter int timeout_cycles = 1024,
    parameter int log_depth      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                quit,
    input  logic                debug,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_out,
    input  logic                write_en,
    input  logic                log_pop,
    output logic [wordsize-1:0] log_data,
    output logic                log_valid,
    output logic                log_overflow,
    output logic [wordsize-1:0] last_wdata,
    output logic [7:0]          debug_count,
    output logic [1:0]          state,
    output logic                done,
    output logic                pass,
    output logic                timeout
);
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
    localparam int WDW = $clog2(timeout_cycles);
    localparam logic [WDW-1:0] WD_MAX = WDW'(timeout_cycles - 1);

    state_t              state_q;
    logic [WDW-1:0]      wd_q;
    logic [7:0]          debug_count_q;
    logic [wordsize-1:0] last_wdata_q;
    logic                debug_q, timeout_q, dbg_rise;

    assign dbg_rise = debug & ~debug_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wd_q          <= '0;
            debug_count_q <= '0;
            last_wdata_q  <= '0;
            debug_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            debug_q <= debug;
            case (state_q)
                IDLE: begin
                    wd_q <= '0;
                    if (enable) state_q <= RUN;
                end
                RUN: begin
                    if (dbg_rise && debug_count_q != 8'hff) debug_count_q <= debug_count_q + 8'd1;
                    if (write_en) last_wdata_q <= data_out;
                    // a debug rise coinciding with quit is included in the verdict
                    if (quit)
                        state_q <= (9'(debug_count_q) + 9'(dbg_rise) == 9'(expected_debug)) ? PASS : FAIL;
                    else if (enable) begin
                        if (wd_q == WD_MAX) begin
                            state_q   <= FAIL;
                            timeout_q <= 1'b1;
                        end else
                            wd_q <= wd_q + WDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign done        = state_q == PASS || state_q == FAIL;
    assign pass        = state_q == PASS;
    assign timeout     = timeout_q;
    assign debug_count = debug_count_q;
    assign last_wdata  = last_wdata_q;

`ifdef REFLET_RUN_MONITOR_LOG_EN
    localparam int AW = $clog2(log_depth);
    logic [wordsize-1:0] mem_q [log_depth];
    logic [wordsize-1:0] log_data_q, head_d;
    logic [AW-1:0]       wptr_q, rptr_q, rptr_d;
    logic [AW:0]         cnt_q, cnt_d;
    logic                ovf_q, push, pop, full, push_ok;

    assign push    = dbg_rise && state_q == RUN;
    assign pop     = log_pop && cnt_q != '0;
    assign full    = cnt_q == (AW+1)'(log_depth);
    assign push_ok = push && (!full || pop);
    assign rptr_d  = rptr_q + AW'(pop);
    assign cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    // the next head bypasses memory when it is the entry being written this cycle
    assign head_d  = cnt_d == '0 ? '0 : (push_ok && wptr_q == rptr_d) ? addr : mem_q[rptr_d];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= addr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            log_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_q + AW'(push_ok);
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            log_data_q <= head_d;
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    assign log_data     = log_data_q;
    assign log_valid    = cnt_q != '0;
    assign log_overflow = ovf_q;
`else
    logic unused_log;
    assign unused_log   = ^{log_pop, addr};
    assign log_data     = '0;
    assign log_valid    = 1'b0;
    assign log_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_reflet_run_monitor.sv
// tb_reflet_run_monitor: random episodes checked cycle by cycle against a queue-based reference model.
module tb_reflet_run_monitor;
    localparam int W = 16, EXP = 2, TO = 16, DEPTH = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3;
`ifdef REFLET_RUN_MONITOR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic         clk, reset, enable, quit, debug, write_en, log_pop;
    logic [W-1:0] addr, data_out, log_data, last_wdata;
    logic         log_valid, log_overflow, done, pass, timeout;
    logic [7:0]   debug_count;
    logic [1:0]   state;

    int           checks, failures;
    int           m_state, m_wd, m_cnt;
    bit           m_ovf, m_to, m_prev;
    logic [W-1:0] m_last;
    logic [W-1:0] m_q[$];
    int           p_quit, p_dbg;

    reflet_run_monitor #(.wordsize(W), .expected_debug(EXP), .timeout_cycles(TO), .log_depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .quit(quit), .debug(debug), .addr(addr),
        .data_out(data_out), .write_en(write_en), .log_pop(log_pop), .log_data(log_data),
        .log_valid(log_valid), .log_overflow(log_overflow), .last_wdata(last_wdata),
        .debug_count(debug_count), .state(state), .done(done), .pass(pass), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_wd = 0; m_cnt = 0;
        m_ovf = 0; m_to = 0; m_prev = 0; m_last = '0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit rise, pop_ok;
        rise   = debug && !m_prev;
        m_prev = debug;
        pop_ok = LOG_EN && log_pop && m_q.size() > 0;
        if (pop_ok) void'(m_q.pop_front());
        if (m_state == S_IDLE) begin
            m_wd = 0;
            if (enable) m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            int total;
            total = m_cnt + int'(rise);
            if (rise && LOG_EN) begin
                if (m_q.size() == DEPTH) m_ovf = 1;
                else m_q.push_back(addr);
            end
            m_cnt = total > 255 ? 255 : total;
            if (write_en) m_last = data_out;
            if (quit) m_state = (total == EXP) ? S_PASS : S_FAIL;
            else if (enable) begin
                m_wd++;
                if (m_wd == TO) begin m_state = S_FAIL; m_to = 1; end
            end
        end
    endtask

    task automatic check_all();
        logic [W-1:0] exp_data;
        check("state", state, m_state);
        check("done", done, m_state >= S_PASS);
        check("pass", pass, m_state == S_PASS);
        check("timeout", timeout, m_to);
        check("debug_count", debug_count, m_cnt);
        check("last_wdata", last_wdata, m_last);
        check("log_valid", log_valid, m_q.size() > 0);
        check("log_overflow", log_overflow, m_ovf);
        exp_data = '0;
        if (m_q.size() > 0) exp_data = m_q[0];
        if (!LOG_EN || m_q.size() > 0) check("log_data", log_data, exp_data);
    endtask

    task automatic drive();
        enable   = $urandom_range(0, 99) < 85;
        quit     = $urandom_range(0, 99) < p_quit;
        debug    = $urandom_range(0, 99) < p_dbg;
        write_en = $urandom_range(0, 1);
        log_pop  = $urandom_range(0, 99) < 30;
        addr     = W'($urandom);
        data_out = W'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        drive();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; enable = 0; quit = 0; debug = 0; write_en = 0; log_pop = 0;
        addr = '0; data_out = '0;
        p_quit = 5; p_dbg = 30;
        #2;
        for (int ep = 0; ep < 150; ep++) begin
            p_quit = $urandom_range(0, 12);
            p_dbg  = $urandom_range(10, 60);
            do_reset();
            for (int c = 0; c < int'($urandom_range(20, 60)); c++) begin
                drive();
                model_step();
                @(negedge clk);
                check_all();
                if ($urandom_range(0, 80) == 0) do_reset();
            end
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
